// File: rtl/datamem_pipe.sv
// Byte-addressed little-endian data memory with a valid/ready request channel
// and a single registered, back-pressurable response slot.
module datamem_pipe #(
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned SIZE_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [SIZE_W-1:0]       req_size,
  input  logic                    req_signed,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*DATA_BYTES-1:0] resp_rdata,
  output logic                    resp_write,
  output logic                    resp_err
);

  localparam int unsigned MIDX_W = $clog2(MEM_BYTES);
  localparam int unsigned LG_DB  = $clog2(DATA_BYTES);
  localparam int unsigned DW     = 8 * DATA_BYTES;

  logic [7:0]        mem [MEM_BYTES];
  logic              accept;
  logic              bad_size;
  logic              misaligned;
  logic              out_of_range;
  logic              err;
  int unsigned       n_int;
  logic [ADDR_W:0]   end_addr;
  logic [MIDX_W-1:0] base;
  logic              sign_bit;
  logic [DW-1:0]     load_data;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign base      = req_addr[MIDX_W-1:0];

  // The end address carries one extra bit so a huge address cannot wrap into range.
  always_comb begin
    bad_size     = 32'(req_size) > LG_DB;
    n_int        = bad_size ? 0 : (32'd1 << req_size);
    misaligned   = |(req_addr & ADDR_W'(n_int - 1));
    end_addr     = {1'b0, req_addr} + (ADDR_W+1)'(n_int);
    out_of_range = end_addr > (ADDR_W+1)'(MEM_BYTES);
    err          = bad_size || misaligned || out_of_range;
  end

  always_comb begin
    load_data = '0;
    sign_bit  = 1'b0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (k < n_int) begin
        load_data[8*k +: 8] = mem[base + MIDX_W'(k)];
        if (k + 1 == n_int)
          sign_bit = mem[base + MIDX_W'(k)][7];
      end
    end
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (k >= n_int)
        load_data[8*k +: 8] = {8{req_signed & sign_bit}};
    end
  end

  // Storage is deliberately not reset; a store accepted before reset persists.
  always_ff @(posedge clk) begin
    if (accept && req_write && !err) begin
      for (int unsigned k = 0; k < DATA_BYTES; k++) begin
        if (k < n_int)
          mem[base + MIDX_W'(k)] <= req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_write <= 1'b0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_write <= req_write;
      resp_err   <= err;
      resp_rdata <= (err || req_write) ? '0 : load_data;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
